// File: rtl/my_divider_32_bit.sv
// Multi-cycle 32-bit restoring divider: one quotient bit per clock, done pulse on completion.
// Define MY_DIV_SIGNED_EN to add the sgn port and two's-complement division.
module my_divider_32_bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
`ifdef MY_DIV_SIGNED_EN
   input  logic        sgn,
`endif
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [4:0]  LAST_ITER = 5'd31;
   localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

   state_t      r_state;
   state_t      w_state_next;
   logic [4:0]  r_cnt;
   logic [31:0] r_rem;
   logic [31:0] r_q;
   logic [31:0] r_den;
   logic [31:0] r_quot;
   logic [31:0] r_remd;
   logic        r_dz;

   logic        w_accept;
   logic        w_div_zero_in;
   logic        w_last;
   logic [32:0] w_r_sh;
   logic [32:0] w_trial;
   logic [31:0] w_rem_next;
   logic [31:0] w_q_next;
   logic [31:0] w_dvd_mag;
   logic [31:0] w_dvs_mag;
   logic [31:0] w_quot_fin;
   logic [31:0] w_rem_fin;

   assign w_accept      = start && (r_state != S_RUN);
   assign w_div_zero_in = (divisor == '0);
   assign w_last        = (r_state == S_RUN) && (r_cnt == LAST_ITER);

   // Shifted partial remainder keeps its carry-out bit so divisors above 2^31 still work.
   assign w_r_sh     = {r_rem, r_q[31]};
   assign w_trial    = w_r_sh - {1'b0, r_den};
   assign w_rem_next = w_trial[32] ? w_r_sh[31:0] : w_trial[31:0];
   assign w_q_next   = {r_q[30:0], ~w_trial[32]};

`ifdef MY_DIV_SIGNED_EN
   logic r_neg_q;
   logic r_neg_r;

   assign w_dvd_mag  = (sgn && dividend[31]) ? (~dividend + 32'd1) : dividend;
   assign w_dvs_mag  = (sgn && divisor[31])  ? (~divisor + 32'd1)  : divisor;
   assign w_quot_fin = r_neg_q ? (~w_q_next + 32'd1)   : w_q_next;
   assign w_rem_fin  = r_neg_r ? (~w_rem_next + 32'd1) : w_rem_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (w_accept) begin
         r_neg_q <= sgn && (dividend[31] ^ divisor[31]);
         r_neg_r <= sgn && dividend[31];
      end
   end
`else
   assign w_dvd_mag  = dividend;
   assign w_dvs_mag  = divisor;
   assign w_quot_fin = w_q_next;
   assign w_rem_fin  = w_rem_next;
`endif

   // NOTE: every branch starts from a default, so no latch can be inferred here.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = w_div_zero_in ? S_DONE : S_RUN;
         S_RUN:   if (r_cnt == LAST_ITER) w_state_next = S_DONE;
         S_DONE:  if (start) w_state_next = w_div_zero_in ? S_DONE : S_RUN;
                  else       w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_rem  <= '0;
         r_q    <= '0;
         r_den  <= '0;
         r_quot <= '0;
         r_remd <= '0;
         r_dz   <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= '0;
         r_rem <= '0;
         r_q   <= w_dvd_mag;
         r_den <= w_dvs_mag;
         r_dz  <= w_div_zero_in;
         if (w_div_zero_in) begin
            r_quot <= ALL_ONES;
            r_remd <= dividend;
         end
      end else if (r_state == S_RUN) begin
         r_cnt <= r_cnt + 5'd1;
         r_rem <= w_rem_next;
         r_q   <= w_q_next;
         if (w_last) begin
            r_quot <= w_quot_fin;
            r_remd <= w_rem_fin;
         end
      end
   end

   assign quotient  = r_quot;
   assign remainder = r_remd;
   assign div_zero  = r_dz;
   assign busy      = (r_state == S_RUN);
   assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_my_divider_32_bit.sv
// Self-checking bench for my_divider_32_bit: directed cases plus randomized operands
// against an arithmetic reference model. Define MY_DIV_SIGNED_EN to cover signed mode.
module tb_my_divider_32_bit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
`ifdef MY_DIV_SIGNED_EN
   logic        sgn;
`endif
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;
   logic        div_zero;

   int checks   = 0;
   int failures = 0;
   logic [31:0] prev_q = '0;
   logic [31:0] prev_r = '0;

   my_divider_32_bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
`ifdef MY_DIV_SIGNED_EN
      .sgn       (sgn),
`endif
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division; signed mode via 64-bit arithmetic so INT_MIN/-1 wraps.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r, output logic dz);
      longint sa, sb, qq, rr;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         qq = sa / sb;
         rr = sa % sb;
         q  = qq[31:0]; r = rr[31:0]; dz = 1'b0;
      end else begin
         q = a / b; r = a % b; dz = 1'b0;
      end
   endfunction

   // Called at a falling edge; returns at the falling edge after the accepting edge.
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
`ifdef MY_DIV_SIGNED_EN
      sgn      = s;
`else
      if (s) $display("signed request ignored in unsigned build");
`endif
      @(negedge clk);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   task automatic wait_result(input string tag, input logic [31:0] exp_q, input logic [31:0] exp_r,
                              input logic exp_dz, input int exp_lat, input int pulse_at);
      int k;
      k = 0;
      while (done !== 1'b1 && k < 40) begin
         check({tag, " busy"}, 32'(busy), 32'd1);
         if (k == 16) check({tag, " hold_q"}, quotient, prev_q);
         if (k == pulse_at) begin
            start = 1'b1; dividend = 32'd50; divisor = 32'd5;
         end
         @(negedge clk);
         start = 1'b0;
         k++;
      end
      check({tag, " latency"}, 32'(k), 32'(exp_lat));
      check({tag, " quotient"}, quotient, exp_q);
      check({tag, " remainder"}, remainder, exp_r);
      check({tag, " div_zero"}, 32'(div_zero), 32'(exp_dz));
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      prev_q = exp_q;
      prev_r = exp_r;
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, " done_low"}, 32'(done), 32'd0);
         check({tag, " hold_q"}, quotient, prev_q);
         check({tag, " hold_r"}, remainder, prev_r);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, " quotient"}, quotient, 32'd0);
      check({tag, " remainder"}, remainder, 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " div_zero"}, 32'(div_zero), 32'd0);
   endtask

   initial begin
      logic [31:0] a, b, eq, er;
      logic        s, edz;

      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
`ifdef MY_DIV_SIGNED_EN
      sgn = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      launch(32'd100, 32'd7, 1'b0);
      wait_result("basic", 32'd14, 32'd2, 1'b0, 32, -1);
      idle("basic", 10);

      launch(32'hFFFF_FFFF, 32'd1, 1'b0);
      wait_result("max_by_1", 32'hFFFF_FFFF, 32'd0, 1'b0, 32, -1);
      idle("max_by_1", 1);
      launch(32'd5, 32'hFFFF_FFFF, 1'b0);
      wait_result("small_by_max", 32'd0, 32'd5, 1'b0, 32, -1);
      idle("small_by_max", 1);

      launch(32'd5, 32'd0, 1'b0);
      wait_result("div0", 32'hFFFF_FFFF, 32'd5, 1'b1, 0, -1);
      idle("div0", 1);
      launch(32'd9, 32'd3, 1'b0);
      wait_result("after_div0", 32'd3, 32'd0, 1'b0, 32, -1);
      idle("after_div0", 1);

      launch(32'd100, 32'd7, 1'b0);
      wait_result("start_in_run", 32'd14, 32'd2, 1'b0, 32, 10);
      launch(32'd50, 32'd5, 1'b0);
      wait_result("start_in_done", 32'd10, 32'd0, 1'b0, 32, -1);
      idle("start_in_done", 1);

      launch(32'd100, 32'd7, 1'b0);
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero_outputs("mid_reset");
      repeat (3) begin
         @(negedge clk);
         check("mid_reset done", 32'(done), 32'd0);
      end
      rst_n  = 1'b1;
      prev_q = '0;
      prev_r = '0;
      idle("post_reset", 2);
      launch(32'd9, 32'd2, 1'b0);
      wait_result("post_reset", 32'd4, 32'd1, 1'b0, 32, -1);
      idle("post_reset", 1);

`ifdef MY_DIV_SIGNED_EN
      launch(32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_result("s_neg7_by_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32, -1);
      idle("s_neg7_by_2", 1);
      launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_result("s_min_by_m1", 32'h8000_0000, 32'd0, 1'b0, 32, -1);
      idle("s_min_by_m1", 1);
      launch(32'hFFFF_FFF9, 32'd2, 1'b0);
      wait_result("u_fff9_by_2", 32'h7FFF_FFFC, 32'd1, 1'b0, 32, -1);
      idle("u_fff9_by_2", 1);
`endif

      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if (i % 7 == 3) b = 32'd0;
`ifdef MY_DIV_SIGNED_EN
         s = 1'($urandom_range(0, 1));
`else
         s = 1'b0;
`endif
         model(a, b, s, eq, er, edz);
         launch(a, b, s);
         wait_result("random", eq, er, edz, (b == 32'd0) ? 0 : 32, -1);
         if (i % 2 == 0) idle("random", 1);
      end
      idle("final", 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/my_divider_32_bit.md
# my_divider_32_bit

Multi-cycle 32-bit restoring divider for the datapath's ALU, the sequential inverse of the multiply path. It accepts a dividend/divisor pair on a one-cycle start strobe, retires one quotient bit per clock, and returns quotient and remainder with a done pulse. Its wide-datapath style matches the existing 32-bit bitwise units. The control unit stalls on busy and captures results on done.

## Interface
- No parameters. The width is fixed at 32.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  32  sampled on the accepting edge
- divisor  input  32  sampled on the accepting edge
- sgn  input  1  signed request; present only with MY_DIV_SIGNED_EN
- quotient  output  32  result; held until the next accepted start
- remainder  output  32  result; held until the next accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when results become valid
- div_zero  output  1  high with results when divisor was 0; held with results

## Operation
- Reset is asynchronous and active-low. The reset state is:
  - FSM in IDLE, iteration counter = 0
  - quotient = 0, remainder = 0
  - busy = 0, done = 0, div_zero = 0
- States:
  - IDLE: on start, go to RUN.
  - RUN: stays for exactly 32 iterations, then goes to DONE.
  - DONE: lasts one cycle, then goes to IDLE. A start in DONE is accepted and goes to RUN.
- Load on the accepting edge:
  - Partial remainder R = 0; Q = dividend; D = divisor; counter = 0.
  - Clear div_zero.
- Iteration, one per RUN cycle:
  - {R,Q} shifts left by 1.
  - Trial T = R − D, computed 33 bits wide.
  - If T is non-negative, R = T[31:0] and Q[0] = 1; otherwise Q[0] = 0.
  - Increment the counter. The last iteration is at counter = 31.
- Divisor 0:
  - Skip RUN; go IDLE → DONE on the accepting edge.
  - quotient = 0xFFFFFFFF, remainder = dividend, div_zero = 1.
- A start while in RUN is ignored. Inputs are not re-sampled.
- Operands may change freely after the accepting edge.
- quotient and remainder update only on the edge that enters DONE. Outputs are stable during RUN.
- Reset asserted mid-operation aborts immediately to the reset state. No done is produced.

## Timing
- Start is sampled high at edge N (normal divisor):
  - busy is high after edges N through N+31.
  - The final iteration happens at edge N+32. At that edge, done = 1, busy = 0, and results are valid.
  - At edge N+33, done = 0.
- Latency from start to done is 32 cycles.
- A start sampled at edge N+32 with done high begins a new operation. Throughput is one result per 33 cycles.
- Divide by zero: done = 1 after edge N. Latency is 1 cycle; busy never rises.
- busy and done are never high together.

## Configuration
- MY_DIV_SIGNED_EN, when defined, adds the sgn port and two's-complement division.
- With sgn = 1:
  - Operands are converted to absolute values at load.
  - On entering DONE, the quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Latency is unchanged.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0, by wrap-around.
  - Divide by zero behaves as in the unsigned case.
- When the macro is undefined, the sgn port does not exist and all division is unsigned.

## Test plan
- Basic: start with 100 / 7 → done exactly 32 cycles after start; quotient = 14, remainder = 2, div_zero = 0. Results hold for 10 idle cycles.
- Extremes: 0xFFFFFFFF / 1 → quotient = 0xFFFFFFFF, remainder = 0. Then 5 / 0xFFFFFFFF → quotient = 0, remainder = 5.
- Divide by zero: 5 / 0 → done on the cycle after start, busy never high; quotient = 0xFFFFFFFF, remainder = 5, div_zero = 1. The next 9 / 3 → div_zero = 0, quotient = 3.
- Handshake:
  - Start 100 / 7, then pulse start with 50 / 5 at cycle 10 → the second start is ignored; result is 14 r 2.
  - A start during the done cycle with 50 / 5 → quotient = 10, remainder = 0, 32 cycles later.
- Reset: drop rst_n at cycle 15 of a 100 / 7 operation → all outputs 0 immediately; no done pulse. After release, 9 / 2 → quotient = 4, remainder = 1.
- Signed (macro defined): sgn = 1, −7 / 2 → quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF. 0x80000000 / 0xFFFFFFFF → quotient = 0x80000000, remainder = 0. With sgn = 0, 0xFFFFFFF9 / 2 → quotient = 0x7FFFFFFC, remainder = 1.
